// File: rtl/rename_alias_table.sv
// Register alias table with the architectural register file behind it.
// Renames source operands to a committed value or the ROB tag of their pending producer.
module rename_alias_table #(
  parameter int ARCH_REGS = 32,
  parameter int ADDR_W    = 5,
  parameter int TAG_W     = 5,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_en,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic [ADDR_W-1:0] alloc_dst_addr,
  input  logic              alloc_dst_wen,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              commit_en,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [ADDR_W-1:0] commit_dst_addr,
  input  logic              commit_dst_wen,
  input  logic [WORD_W-1:0] commit_value,
  input  logic              commit_br_taken,
  input  logic              commit_exp_en,
  output logic              rs1_ready,
  output logic [WORD_W-1:0] rs1_value,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic              rs2_ready,
  output logic [WORD_W-1:0] rs2_value,
  output logic [TAG_W-1:0]  rs2_tag,
  output logic              flush_out
);

  logic [WORD_W-1:0]    arf     [ARCH_REGS];
  logic [TAG_W-1:0]     map_tag [ARCH_REGS];
  logic [ARCH_REGS-1:0] busy;

  logic flush;
  logic commit_hit;
  logic commit_wr;
  logic alloc_wr;

  logic [ADDR_W-1:0] src_addr  [2];
  logic              src_ready [2];
  logic [WORD_W-1:0] src_value [2];
  logic [TAG_W-1:0]  src_tag   [2];

  assign flush      = commit_en & (commit_br_taken | commit_exp_en);
  assign commit_hit = commit_en & commit_dst_wen;
  assign commit_wr  = commit_hit & (commit_dst_addr != '0);
  assign alloc_wr   = alloc_en & alloc_dst_wen & (alloc_dst_addr != '0) & ~flush;

  assign src_addr[0] = rs1_addr;
  assign src_addr[1] = rs2_addr;

  // Both read ports see pre-edge state; a retiring producer is forwarded straight through.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      src_ready[p] = 1'b1;
      src_value[p] = '0;
      src_tag[p]   = '0;
      if (src_addr[p] != '0) begin
        if (busy[src_addr[p]]) begin
          if (commit_hit && (commit_tag == map_tag[src_addr[p]])) begin
            src_value[p] = commit_value;
          end else begin
            src_ready[p] = 1'b0;
            src_tag[p]   = map_tag[src_addr[p]];
          end
        end else begin
          src_value[p] = arf[src_addr[p]];
        end
      end
    end
  end

  assign rs1_ready = src_ready[0];
  assign rs1_value = src_value[0];
  assign rs1_tag   = src_tag[0];
  assign rs2_ready = src_ready[1];
  assign rs2_value = src_value[1];
  assign rs2_tag   = src_tag[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        arf[i]     <= '0;
        map_tag[i] <= '0;
      end
    end else if (commit_wr) begin
      arf[commit_dst_addr] <= commit_value;
    end
  end

  // The allocate update follows the commit clear so a same-destination rename keeps its new tag busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      flush_out <= 1'b0;
    end else begin
      flush_out <= flush;
      if (flush) begin
        busy <= '0;
      end else begin
        if (commit_wr && (map_tag[commit_dst_addr] == commit_tag)) begin
          busy[commit_dst_addr] <= 1'b0;
        end
        if (alloc_wr) begin
          busy[alloc_dst_addr]    <= 1'b1;
          map_tag[alloc_dst_addr] <= alloc_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_alias_table.sv
// Scoreboard bench for rename_alias_table: stimulus queues expected lookups and flush,
// an independent monitor compares them against the DUT each cycle.
module tb_rename_alias_table;

  logic        clk;
  logic        rst_n;
  logic        alloc_en;
  logic [4:0]  alloc_tag;
  logic [4:0]  alloc_dst_addr;
  logic        alloc_dst_wen;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        commit_en;
  logic [4:0]  commit_tag;
  logic [4:0]  commit_dst_addr;
  logic        commit_dst_wen;
  logic [31:0] commit_value;
  logic        commit_br_taken;
  logic        commit_exp_en;
  logic        rs1_ready;
  logic [31:0] rs1_value;
  logic [4:0]  rs1_tag;
  logic        rs2_ready;
  logic [31:0] rs2_value;
  logic [4:0]  rs2_tag;
  logic        flush_out;

  typedef struct {
    logic        chk1;
    logic [37:0] exp1;
    logic        chk2;
    logic [37:0] exp2;
    logic        chkf;
    logic        expf;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    total_checks;
  int    passed_checks;

  rename_alias_table dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_en        (alloc_en),
    .alloc_tag       (alloc_tag),
    .alloc_dst_addr  (alloc_dst_addr),
    .alloc_dst_wen   (alloc_dst_wen),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .commit_en       (commit_en),
    .commit_tag      (commit_tag),
    .commit_dst_addr (commit_dst_addr),
    .commit_dst_wen  (commit_dst_wen),
    .commit_value    (commit_value),
    .commit_br_taken (commit_br_taken),
    .commit_exp_en   (commit_exp_en),
    .rs1_ready       (rs1_ready),
    .rs1_value       (rs1_value),
    .rs1_tag         (rs1_tag),
    .rs2_ready       (rs2_ready),
    .rs2_value       (rs2_value),
    .rs2_tag         (rs2_tag),
    .flush_out       (flush_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [37:0] rd(input logic r, input logic [31:0] v, input logic [4:0] t);
    return {r, v, t};
  endfunction

  task automatic applyStimulus(input logic a_en, input logic [4:0] a_tag, input logic [4:0] a_dst,
                               input logic c_en, input logic [4:0] c_tag, input logic [4:0] c_dst,
                               input logic [31:0] c_val, input logic c_br, input logic c_exp,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    alloc_en        = a_en;
    alloc_tag       = a_tag;
    alloc_dst_addr  = a_dst;
    alloc_dst_wen   = a_en;
    commit_en       = c_en;
    commit_tag      = c_tag;
    commit_dst_addr = c_dst;
    commit_dst_wen  = c_en;
    commit_value    = c_val;
    commit_br_taken = c_br;
    commit_exp_en   = c_exp;
    rs1_addr        = r1;
    rs2_addr        = r2;
  endtask

  task automatic pushExpect(input string name, input logic c1, input logic [37:0] e1,
                            input logic c2, input logic [37:0] e2, input logic cf, input logic ef);
    exp_t e;
    e.chk1 = c1;
    e.exp1 = e1;
    e.chk2 = c2;
    e.exp2 = e2;
    e.chkf = cf;
    e.expf = ef;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [37:0] act, input logic [37:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  // Monitor: samples mid-low-phase, well clear of the rising edge, and retires one entry per cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.chk1) checkOutput({n, ".rs1"}, {rs1_ready, rs1_value, rs1_tag}, e.exp1);
        if (e.chk2) checkOutput({n, ".rs2"}, {rs2_ready, rs2_value, rs2_tag}, e.exp2);
        if (e.chkf) checkOutput({n, ".flush"}, {37'd0, flush_out}, {37'd0, e.expf});
      end
    end
  end

  initial begin
    int waited;
    total_checks    = 0;
    passed_checks   = 0;
    rst_n           = 1'b0;
    alloc_en        = 1'b0;
    alloc_tag       = '0;
    alloc_dst_addr  = '0;
    alloc_dst_wen   = 1'b0;
    commit_en       = 1'b0;
    commit_tag      = '0;
    commit_dst_addr = '0;
    commit_dst_wen  = 1'b0;
    commit_value    = '0;
    commit_br_taken = 1'b0;
    commit_exp_en   = 1'b0;
    rs1_addr        = '0;
    rs2_addr        = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 5,0);
    pushExpect("reset", 1, rd(1,0,0), 1, rd(1,0,0), 1, 0);

    applyStimulus(1,3,5, 0,0,0,32'h0,0,0, 5,0);
    pushExpect("alloc_same_cycle", 1, rd(1,0,0), 1, rd(1,0,0), 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 5,0);
    pushExpect("x5_pending", 1, rd(0,0,3), 1, rd(1,0,0), 0, 0);
    applyStimulus(0,0,0, 1,3,5,32'hDEADBEEF,0,0, 5,7);
    pushExpect("x5_bypass", 1, rd(1,32'hDEADBEEF,0), 1, rd(1,0,0), 1, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 5,0);
    pushExpect("x5_arf", 1, rd(1,32'hDEADBEEF,0), 0, '0, 0, 0);

    applyStimulus(1,3,7, 0,0,0,32'h0,0,0, 7,0);
    pushExpect("x7_pre", 1, rd(1,0,0), 0, '0, 0, 0);
    applyStimulus(1,4,7, 0,0,0,32'h0,0,0, 7,0);
    pushExpect("x7_tag3", 1, rd(0,0,3), 0, '0, 0, 0);
    applyStimulus(0,0,0, 1,3,7,32'h11,0,0, 7,5);
    pushExpect("x7_old_commit", 1, rd(0,0,4), 1, rd(1,32'hDEADBEEF,0), 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 7,0);
    pushExpect("x7_still_tag4", 1, rd(0,0,4), 0, '0, 0, 0);
    applyStimulus(0,0,0, 1,4,7,32'h22,0,0, 7,0);
    pushExpect("x7_bypass", 1, rd(1,32'h22,0), 0, '0, 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 7,0);
    pushExpect("x7_arf", 1, rd(1,32'h22,0), 0, '0, 0, 0);

    applyStimulus(1,9,0, 0,0,0,32'h0,0,0, 0,0);
    pushExpect("x0_alloc", 1, rd(1,0,0), 0, '0, 0, 0);
    applyStimulus(0,0,0, 1,9,0,32'h55,0,0, 0,0);
    pushExpect("x0_commit", 1, rd(1,0,0), 1, rd(1,0,0), 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 0,0);
    pushExpect("x0_after", 1, rd(1,0,0), 0, '0, 1, 0);

    applyStimulus(1,1,2, 0,0,0,32'h0,0,0, 2,3);
    pushExpect("fl_alloc1", 0, '0, 0, '0, 0, 0);
    applyStimulus(1,2,3, 0,0,0,32'h0,0,0, 2,3);
    pushExpect("fl_alloc2", 1, rd(0,0,1), 1, rd(1,0,0), 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 2,3);
    pushExpect("fl_busy", 1, rd(0,0,1), 1, rd(0,0,2), 0, 0);
    applyStimulus(1,6,4, 1,1,2,32'h40,1,0, 2,3);
    pushExpect("fl_cycle", 1, rd(1,32'h40,0), 1, rd(0,0,2), 1, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 2,3);
    pushExpect("fl_after", 1, rd(1,32'h40,0), 1, rd(1,0,0), 1, 1);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 4,3);
    pushExpect("fl_x4", 1, rd(1,0,0), 1, rd(1,0,0), 1, 0);

    applyStimulus(1,10,9, 0,0,0,32'h0,0,0, 9,0);
    pushExpect("ex_alloc", 0, '0, 0, '0, 0, 0);
    applyStimulus(0,0,0, 1,10,9,32'h99,0,1, 9,0);
    pushExpect("ex_bypass", 1, rd(1,32'h99,0), 0, '0, 1, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 9,0);
    pushExpect("ex_after", 1, rd(1,32'h99,0), 0, '0, 1, 1);

    applyStimulus(1,5,6, 0,0,0,32'h0,0,0, 6,0);
    pushExpect("sc_alloc5", 1, rd(1,0,0), 0, '0, 1, 0);
    applyStimulus(1,8,6, 1,5,6,32'h77,0,0, 6,0);
    pushExpect("sc_both", 1, rd(1,32'h77,0), 0, '0, 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 6,0);
    pushExpect("sc_tag8", 1, rd(0,0,8), 0, '0, 0, 0);
    applyStimulus(0,0,0, 1,12,1,32'h1,0,1, 6,1);
    pushExpect("sc_flush", 1, rd(0,0,8), 0, '0, 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 6,1);
    pushExpect("sc_arf", 1, rd(1,32'h77,0), 1, rd(1,32'h1,0), 1, 1);

    applyStimulus(1,7,10, 0,0,0,32'h0,0,0, 10,6);
    pushExpect("rst_alloc", 0, '0, 0, '0, 0, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 10,6);
    pushExpect("rst_pending", 1, rd(0,0,7), 1, rd(1,32'h77,0), 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 10,6);
    pushExpect("rst_cleared", 1, rd(1,0,0), 1, rd(1,0,0), 1, 0);
    applyStimulus(0,0,0, 0,0,0,32'h0,0,0, 0,0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      total_checks++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
